// File: rtl/tag_pkg.sv
// Shared types and helpers for the rename-tag free pool: default tag width,
// tag type, pointer width and the wrapping pointer increment.
package tag_pkg;

  localparam int DEF_TAG_WIDTH = 6;
  localparam int DEF_DEPTH     = 2 ** DEF_TAG_WIDTH;

  typedef logic [DEF_TAG_WIDTH-1:0] tag_t;

  // A one-entry pool still needs a 1-bit pointer to index its single slot.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int PTR_W = ptr_width(DEF_DEPTH);

  // Depth is a power of two, so wrapping modulo depth is a mask.
  function automatic int unsigned ptr_inc(input int unsigned ptr,
                                          input int unsigned n,
                                          input int unsigned depth);
    return (ptr + n) & (depth - 1);
  endfunction

endpackage

// File: rtl/tag_slot_array.sv
// Storage for the free pool: DEPTH tag registers, two write ports, one
// combinational read port, loaded with slot[i]=i on reset and on flush.
module tag_slot_array #(
  parameter int TAG_WIDTH = 6,
  parameter int DEPTH     = 64,
  parameter int PTR_W     = 6
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 we0,
  input  logic [PTR_W-1:0]     waddr0,
  input  logic [TAG_WIDTH-1:0] wdata0,
  input  logic                 we1,
  input  logic [PTR_W-1:0]     waddr1,
  input  logic [TAG_WIDTH-1:0] wdata1,
  input  logic [PTR_W-1:0]     raddr,
  output logic [TAG_WIDTH-1:0] rdata
);

  logic [TAG_WIDTH-1:0] slot [DEPTH];

  // NOTE: this array is reset on purpose - the pool's contents define the free
  // tags, so it must come out of reset holding every tag. Plain data RAMs
  // would normally skip the reset so they can map onto memory macros.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) slot[i] <= TAG_WIDTH'(i);
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) slot[i] <= TAG_WIDTH'(i);
    end else begin
      if (we0) slot[waddr0] <= wdata0;
      if (we1) slot[waddr1] <= wdata1;
    end
  end

  assign rdata = slot[raddr];

endmodule

// File: rtl/tag_free_list.sv
// Free-tag pool between CDB and dispatch: hands out the head tag, accepts up
// to two returned tags per cycle, tracks the free count and sticky errors.
module tag_free_list
  import tag_pkg::*;
#(
  parameter int TAG_WIDTH = DEF_TAG_WIDTH,
  parameter int DEPTH     = 2 ** TAG_WIDTH,
  parameter int NUM_RET   = 2,
  parameter int AE_THRESH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 alloc_req,
  output logic [TAG_WIDTH-1:0] alloc_tag,
  output logic                 alloc_valid,
  input  logic                 ret0_valid,
  input  logic [TAG_WIDTH-1:0] ret0_tag,
  input  logic                 ret1_valid,
  input  logic [TAG_WIDTH-1:0] ret1_tag,
  output logic [TAG_WIDTH:0]   free_count,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_empty,
  output logic                 err_underflow,
  output logic                 err_overflow
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = TAG_WIDTH + 2;

  typedef logic [PW-1:0] ptr_t;

  ptr_t                 rd_ptr, wr_ptr;
  logic                 alloc_acc;
  logic                 ret1_use;
  logic                 ret0_ok, ret1_ok;
  logic                 drop;
  logic [1:0]           ret_cnt;
  logic [CW-1:0]        space;
  logic                 we0, we1;
  logic [TAG_WIDTH-1:0] wdata0;
  ptr_t                 waddr1;

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    alloc_acc = 1'b0;
    ret1_use  = 1'b0;
    ret0_ok   = 1'b0;
    ret1_ok   = 1'b0;
    drop      = 1'b0;
    space     = '0;
    alloc_acc = alloc_req && !empty;
    ret1_use  = (NUM_RET == 2) && ret1_valid;
    // An accepted alloc frees a slot this same edge, so it adds to the room.
    space     = CW'(DEPTH) - CW'(free_count) + CW'(alloc_acc);
    ret0_ok   = ret0_valid && (space != '0);
    ret1_ok   = ret1_use && (space > CW'(ret0_ok));
    drop      = (ret0_valid && !ret0_ok) || (ret1_use && !ret1_ok);
  end

  assign ret_cnt = 2'(ret0_ok) + 2'(ret1_ok);

  // Port 0 takes the first accepted return, port 1 the second one.
  assign we0    = !flush && (ret0_ok || ret1_ok);
  assign wdata0 = ret0_ok ? ret0_tag : ret1_tag;
  assign we1    = !flush && ret0_ok && ret1_ok;
  assign waddr1 = PW'(ptr_inc(32'(wr_ptr), 32'd1, DEPTH));

  tag_slot_array #(
    .TAG_WIDTH (TAG_WIDTH),
    .DEPTH     (DEPTH),
    .PTR_W     (PW)
  ) u_slots (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .we0     (we0),
    .waddr0  (wr_ptr),
    .wdata0  (wdata0),
    .we1     (we1),
    .waddr1  (waddr1),
    .wdata1  (ret1_tag),
    .raddr   (rd_ptr),
    .rdata   (alloc_tag)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      free_count <= (TAG_WIDTH+1)'(DEPTH);
    end else if (flush) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      free_count <= (TAG_WIDTH+1)'(DEPTH);
    end else begin
      if (alloc_acc) rd_ptr <= PW'(ptr_inc(32'(rd_ptr), 32'd1, DEPTH));
      wr_ptr     <= PW'(ptr_inc(32'(wr_ptr), 32'(ret_cnt), DEPTH));
      free_count <= free_count + (TAG_WIDTH+1)'(ret_cnt)
                               - (TAG_WIDTH+1)'(alloc_acc);
    end
  end

  // Error flags survive flush; only reset_n clears them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_underflow <= 1'b0;
      err_overflow  <= 1'b0;
    end else if (!flush) begin
      if (alloc_req && empty) err_underflow <= 1'b1;
      if (drop)               err_overflow  <= 1'b1;
    end
  end

  assign empty        = (free_count == '0);
  assign full         = (free_count == (TAG_WIDTH+1)'(DEPTH));
  assign almost_empty = (32'(free_count) <= AE_THRESH);
  assign alloc_valid  = !empty;

endmodule

// File: tb/tb_tag_free_list.sv
// Self-checking bench for tag_free_list: a queue model of the free pool is
// compared against the DUT every cycle, plus directed literal expectations.
module tb_tag_free_list;

  localparam int TW    = 6;
  localparam int DEPTH = 64;
  localparam int AE    = 4;

  logic          clk;
  logic          reset_n;
  logic          flush;
  logic          alloc_req;
  logic [TW-1:0] alloc_tag;
  logic          alloc_valid;
  logic          ret0_valid;
  logic [TW-1:0] ret0_tag;
  logic          ret1_valid;
  logic [TW-1:0] ret1_tag;
  logic [TW:0]   free_count;
  logic          empty;
  logic          full;
  logic          almost_empty;
  logic          err_underflow;
  logic          err_overflow;

  tag_free_list #(
    .TAG_WIDTH (TW),
    .DEPTH     (DEPTH),
    .NUM_RET   (2),
    .AE_THRESH (AE)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .flush         (flush),
    .alloc_req     (alloc_req),
    .alloc_tag     (alloc_tag),
    .alloc_valid   (alloc_valid),
    .ret0_valid    (ret0_valid),
    .ret0_tag      (ret0_tag),
    .ret1_valid    (ret1_valid),
    .ret1_tag      (ret1_tag),
    .free_count    (free_count),
    .empty         (empty),
    .full          (full),
    .almost_empty  (almost_empty),
    .err_underflow (err_underflow),
    .err_overflow  (err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  // Model: the free pool is an ordered queue of tags, head first.
  int mq[$];
  bit m_unf, m_ovf;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_fill();
    mq.delete();
    for (int i = 0; i < DEPTH; i++) mq.push_back(i);
  endtask

  task automatic model_update();
    int  room;
    bit  take;
    take = alloc_req && (mq.size() > 0);
    if (flush) begin
      model_fill();
    end else begin
      if (alloc_req && mq.size() == 0) m_unf = 1'b1;
      room = DEPTH - mq.size() + (take ? 1 : 0);
      if (take) void'(mq.pop_front());
      if (ret0_valid) begin
        if (room > 0) begin mq.push_back(int'(ret0_tag)); room--; end
        else m_ovf = 1'b1;
      end
      if (ret1_valid) begin
        if (room > 0) begin mq.push_back(int'(ret1_tag)); room--; end
        else m_ovf = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("alloc_valid", alloc_valid, mq.size() != 0);
      if (mq.size() != 0) check("alloc_tag", alloc_tag, mq[0]);
      check("free_count", free_count, mq.size());
      check("empty", empty, mq.size() == 0);
      check("full", full, mq.size() == DEPTH);
      check("almost_empty", almost_empty, mq.size() <= AE);
      check("err_underflow", err_underflow, m_unf);
      check("err_overflow", err_overflow, m_ovf);
    end
  end

  // Inputs change just after a negedge; the model advances at the posedge.
  task automatic step(input bit a, input bit v0, input int t0,
                      input bit v1, input int t1, input bit f);
    alloc_req  = a;
    ret0_valid = v0;
    ret0_tag   = TW'(t0);
    ret1_valid = v1;
    ret1_tag   = TW'(t1);
    flush      = f;
    @(posedge clk);
    model_update();
    @(negedge clk);
    alloc_req  = 1'b0;
    ret0_valid = 1'b0;
    ret1_valid = 1'b0;
    flush      = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; alloc_req = 1'b0;
    ret0_valid = 1'b0; ret0_tag = '0; ret1_valid = 1'b0; ret1_tag = '0;
    model_fill(); m_unf = 1'b0; m_ovf = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // 1: reset state, then drain the pool in order
    check("rst_alloc_tag", alloc_tag, 0);
    check("rst_free_count", free_count, 64);
    check("rst_full", full, 1);
    check("rst_alloc_valid", alloc_valid, 1);
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_tag", alloc_tag, i);
      if (i == 59) check("ae_at_5", almost_empty, 0);
      if (i == 60) check("ae_at_4", almost_empty, 1);
      step(1, 0, 0, 0, 0, 0);
    end
    check("drained_empty", empty, 1);
    check("drained_alloc_valid", alloc_valid, 0);
    check("drained_ae", almost_empty, 1);

    // 2: two returns into an empty pool, ch0 first
    step(0, 1, 5, 1, 9, 0);
    check("t2_free_count", free_count, 2);
    check("t2_head", alloc_tag, 5);
    step(1, 0, 0, 0, 0, 0);
    check("t2_second", alloc_tag, 9);
    step(1, 0, 0, 0, 0, 0);

    // 3: alloc on empty with same-cycle return: no bypass, underflow flagged
    step(1, 1, 7, 0, 0, 0);
    check("t3_underflow", err_underflow, 1);
    check("t3_head", alloc_tag, 7);
    check("t3_free_count", free_count, 1);

    // 4: full pool, alloc plus two returns: only ch0 fits
    step(0, 0, 0, 0, 0, 1);
    check("t4_flush_full", full, 1);
    step(1, 1, 3, 1, 4, 0);
    check("t4_overflow", err_overflow, 1);
    check("t4_free_count", free_count, 64);
    check("t4_head", alloc_tag, 1);

    // 5: wrap of the read pointer across slot 63 -> 0
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 60; i++) step(1, 0, 0, 0, 0, 0);
    check("t5_after_60", free_count, 4);
    for (int j = 0; j < 30; j++)
      step(0, 1, (100 + 2*j) % 64, 1, (100 + 2*j + 1) % 64, 0);
    check("t5_after_ret", free_count, 64);
    for (int i = 0; i < 10; i++) begin
      check("t5_wrap_tag", alloc_tag, (i < 4) ? 60 + i : (100 + i - 4) % 64);
      step(1, 0, 0, 0, 0, 0);
    end
    check("t5_final_count", free_count, 54);

    // 6: flush discards same-cycle traffic but keeps errors; then async reset
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0, 0);
    check("t6_before_flush", free_count, 44);
    step(1, 1, 11, 0, 0, 1);
    check("t6_flush_count", free_count, 64);
    check("t6_flush_tag", alloc_tag, 0);
    check("t6_flush_unf", err_underflow, 1);
    check("t6_flush_ovf", err_overflow, 1);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    alloc_req = 1'b1; ret0_valid = 1'b1; ret0_tag = TW'(1);
    #3;
    reset_n = 1'b0;
    model_fill(); m_unf = 1'b0; m_ovf = 1'b0;
    #1;
    check("t6_rst_count", free_count, 64);
    check("t6_rst_tag", alloc_tag, 0);
    check("t6_rst_full", full, 1);
    check("t6_rst_empty", empty, 0);
    check("t6_rst_valid", alloc_valid, 1);
    check("t6_rst_ae", almost_empty, 0);
    check("t6_rst_unf", err_underflow, 0);
    check("t6_rst_ovf", err_overflow, 0);
    alloc_req = 1'b0; ret0_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    step(1, 0, 0, 0, 0, 0);
    check("t6_post_rst_tag", alloc_tag, 1);
    check("t6_post_rst_count", free_count, 63);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
